arb4_decode_ctrl: RTL and testbench
===================================

# arb4_decode_ctrl

Round-robin arbiter that shares one 4-way resource among four requesters and drives the active-low one-hot select lines a 2-to-4 decoder would produce. It sits in front of the shared resource and replaces a free-running {A,B} select with a registered, fair, bounded-hold grant. It also exports the binary grant code so downstream logic can mux data with the same index.

## Interface

- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester waits. Legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: arbiter enable. While low, no new grant is issued and any current grant is released.
- `req` input 4: active-high requests; `req[i]` belongs to requester i.
- `gnt_n` output 4: active-low one-hot grant. 4'b1111 means no grant; 4'b1110 grants 0, 4'b1101 grants 1, 4'b1011 grants 2, 4'b0111 grants 3.
- `gnt_idx` output 2: binary index of the current or most recent grant.
- `gnt_valid` output 1: high exactly when `gnt_n` != 4'b1111.

## Operation

- **Reset (async, immediate):**
  - `gnt_n` = 4'b1111, `gnt_idx` = 2'b00, `gnt_valid` = 0.
  - State = IDLE, `last` = 2'd3, `hold_cnt` = 0.
  - Because `last` resets to 3, requester 0 has first priority.
- **States:** IDLE and GRANT.
- **IDLE:**
  - `gnt_n` = 4'b1111 and `gnt_valid` = 0. `gnt_idx` holds its previous value.
  - If `en`=1 and `req` != 0, pick the first asserted requester scanning `last+1`, `last+2`, `last+3`, `last` (mod 4; wrap 3→0).
  - Register the pick into `gnt_idx` and `last`, drive the matching `gnt_n`, set `gnt_valid`=1, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - Outputs stay constant.
  - `hold_cnt` increments each cycle and saturates at MAX_HOLD-1.
  - Release means: next edge goes to IDLE and drives `gnt_n` = 4'b1111.
  - Release when any of the following holds:
    - (a) `req[gnt_idx]` = 0;
    - (b) `en` = 0;
    - (c) `hold_cnt` == MAX_HOLD-1 and at least one other bit of `req` is set.
  - If (c)'s counter condition holds but no other request is pending, keep the grant and keep `hold_cnt` saturated.
- **Fairness:** after any release, the released index becomes lowest priority.
- Grants are always registered; no combinational path from `req` to `gnt_n`.
- `gnt_n` never has more than one zero bit.
- `gnt_valid` == (state == GRANT).
- **Simultaneous events:**
  - Request drop and timeout in the same cycle is a single release.
  - Reset asserted during GRANT forces the reset values immediately, with no partial state.

## Timing

- **Grant latency:** `req` high and sampled in IDLE at edge N gives `gnt_n` valid after edge N (1 cycle from request to grant).
- **Release latency:** a release condition sampled at edge M makes `gnt_n` = 4'b1111 after edge M.
- **Turnaround:** at least one IDLE cycle between consecutive grants, including back-to-back requests.
- **Maximum continuous hold with contention:** MAX_HOLD cycles.
- **Worst-case wait** for a continuously asserting requester, all four requesting: 3 × (MAX_HOLD + 1) cycles.
- `en` falling during GRANT: grant drops after the next edge.
- `en` rising with requests pending: grant after the next edge.

## Test plan

- **Reset check:** assert `rst` mid-grant (`gnt_n`=4'b1011) → outputs go immediately to `gnt_n`=4'b1111, `gnt_idx`=0, `gnt_valid`=0. After release, `req`=4'b1111 → first grant is 4'b1110.
- **Single requester:** `req`=4'b0100 held 20 cycles with MAX_HOLD=8 → `gnt_n`=4'b1011, `gnt_idx`=2, continuous for all cycles (no timeout without contention). Drop `req` → 4'b1111 one edge later.
- **Round-robin:** `req`=4'b1111 held, MAX_HOLD=4 → grant sequence 0,1,2,3,0. Each grant lasts 4 cycles, each followed by exactly 1 idle cycle.
- **Wrap and priority:** after a grant to 3 is released, `req`=4'b1001 → grant 0. After grant 0 is released, `req`=4'b1001 → grant 3.
- **Enable gating:** `en`=0 with `req`=4'b0010 → no grant for 10 cycles. Raise `en` → grant 1 after one edge. Drop `en` during the grant → release after one edge.
- **Timeout versus early drop:** with MAX_HOLD=3, `req`=4'b0011 → requester 0 is released after 3 cycles, then 1 idle cycle, then requester 1 is granted. If requester 0 drops at cycle 2, release happens at cycle 2 and there is no double release.

Source files
------------

// File: rtl/arb4_decode_ctrl.sv
// arb4_decode_ctrl: round-robin arbiter for one shared 4-way resource.
// Drives registered active-low one-hot select lines (what a 2-to-4 decoder
// would produce), the binary grant index and a grant-valid flag.
// A grant is held for at most MAX_HOLD cycles while another requester waits.
// At least one idle cycle always separates two consecutive grants.
module arb4_decode_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt_n,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    // Handshake: requester i raises req[i] and keeps it high while it wants
    // the resource. The grant appears one edge after req is sampled in IDLE.
    // It stays until the requester drops req[i], en falls, or the hold limit
    // expires with another requester waiting. Dropping req[i] releases the
    // grant on the next edge.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] last;
    logic [7:0] hold_cnt;

    logic [1:0] pick;
    logic       pick_valid;
    logic [1:0] cand;
    logic [3:0] owner_mask;
    logic       others_waiting;
    logic       hold_expired;
    logic       release_gnt;

    // Rotating priority scan: the first requester after `last` wins.
    // `last` itself is checked last. The scan runs from the lowest priority
    // to the highest so the highest-priority hit is written last.
    always_comb begin
        pick       = last;
        pick_valid = 1'b0;
        cand       = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Release conditions for the current owner.
    always_comb begin
        owner_mask     = 4'b0001 << gnt_idx;
        others_waiting = |(req & ~owner_mask);
        hold_expired   = (hold_cnt == HOLD_LAST);
        release_gnt    = !req[gnt_idx] || !en || (hold_expired && others_waiting);
    end

    // Grant FSM with registered outputs; no combinational req-to-gnt_n path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            hold_cnt  <= 8'd0;
            gnt_n     <= 4'b1111;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gnt_n     <= 4'b1111;
                    gnt_valid <= 1'b0;
                    if (en && pick_valid) begin
                        state     <= GRANT;
                        gnt_idx   <= pick;
                        last      <= pick;
                        gnt_n     <= ~(4'b0001 << pick);
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_gnt) begin
                        state     <= IDLE;
                        gnt_n     <= 4'b1111;
                        gnt_valid <= 1'b0;
                    end else if (!hold_expired) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_n     <= 4'b1111;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb4_decode_ctrl.sv
// Bench for arb4_decode_ctrl: three instances (MAX_HOLD = 8, 4, 3) share
// one stimulus stream. A cycle-level behavioural model tracks each one.
// Directed scenarios also check explicit constant expectations.
module tb_arb4_decode_ctrl;

    localparam int MH [3] = '{8, 4, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gn [3];
    logic [1:0] gi [3];
    logic       gv [3];

    int checks = 0;
    int errors = 0;

    // behavioural model state: owner (-1 = none), visible grant cycles, last winner
    int m_owner [3];
    int m_held  [3];
    int m_last  [3];
    int m_idx   [3];

    always #5 clk = ~clk;

    arb4_decode_ctrl #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt_n(gn[0]), .gnt_idx(gi[0]), .gnt_valid(gv[0]));
    arb4_decode_ctrl #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt_n(gn[1]), .gnt_idx(gi[1]), .gnt_valid(gv[1]));
    arb4_decode_ctrl #(.MAX_HOLD(3)) dut3 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt_n(gn[2]), .gnt_idx(gi[2]), .gnt_valid(gv[2]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owner[i] = -1;
            m_held[i]  = 0;
            m_last[i]  = 3;
            m_idx[i]   = 0;
        end
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_update();
        logic [3:0] others;
        int c;
        for (int i = 0; i < 3; i++) begin
            if (m_owner[i] >= 0) begin
                others = req & ~(4'b0001 << m_owner[i]);
                if (!req[m_owner[i]] || !en || (m_held[i] >= MH[i] && others != 4'b0000))
                    m_owner[i] = -1;
                else
                    m_held[i]++;
            end else if (en && req != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last[i] + k) % 4;
                    if (req[c] && m_owner[i] < 0) begin
                        m_owner[i] = c;
                        m_last[i]  = c;
                        m_idx[i]   = c;
                        m_held[i]  = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] exp_n;
        for (int i = 0; i < 3; i++) begin
            exp_n = (m_owner[i] < 0) ? 4'b1111 : ~(4'b0001 << m_owner[i]);
            chk($sformatf("model gnt_n mh=%0d", MH[i]), 8'(gn[i]), 8'(exp_n));
            chk($sformatf("model gnt_idx mh=%0d", MH[i]), 8'(gi[i]), 8'(m_idx[i]));
            chk($sformatf("model gnt_valid mh=%0d", MH[i]), 8'(gv[i]), 8'(m_owner[i] >= 0));
        end
    endtask

    // Advance one edge, update the model, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_update();
        @(negedge clk);
        check_model();
    endtask

    // Asynchronous reset: outputs must change before any clock edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk("reset gnt_n", 8'(gn[i]), 8'h0f);
            chk("reset gnt_idx", 8'(gi[i]), 8'h00);
            chk("reset gnt_valid", 8'(gv[i]), 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] e;
        model_reset();

        // reset and mid-grant asynchronous reset
        @(negedge clk);
        pulse_reset();
        req = 4'b0100;
        step();
        chk("pre-reset grant 2", 8'(gn[0]), 8'h0b);
        #2;
        pulse_reset();
        req = 4'b1111;
        step();
        chk("first grant after reset", 8'(gn[0]), 8'h0e);

        // single requester held without contention
        req = 4'b0000;
        step();
        step();
        req = 4'b0100;
        for (int c = 0; c < 21; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                chk("single gnt_n", 8'(gn[i]), 8'h0b);
                chk("single gnt_idx", 8'(gi[i]), 8'h02);
            end
        end
        req = 4'b0000;
        step();
        chk("single release", 8'(gn[0]), 8'h0f);

        // round robin, MAX_HOLD=4: 0,1,2,3,0 with 4-cycle grants and 1 idle
        pulse_reset();
        req = 4'b1111;
        for (int c = 1; c <= 25; c++) begin
            step();
            e = (((c - 1) % 5) < 4) ? ~(4'b0001 << (((c - 1) / 5) % 4)) : 4'b1111;
            chk($sformatf("round robin c=%0d", c), 8'(gn[1]), 8'(e));
        end

        // wrap and priority
        pulse_reset();
        req = 4'b1000;
        step();
        req = 4'b0000;
        step();
        req = 4'b1001;
        step();
        chk("wrap 3->0", 8'(gn[0]), 8'h0e);
        req = 4'b0000;
        step();
        req = 4'b1001;
        step();
        chk("priority 0->3", 8'(gn[0]), 8'h07);
        req = 4'b0000;
        step();

        // enable gating
        en  = 1'b0;
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("en low no grant", 8'(gn[0]), 8'h0f);
        end
        en = 1'b1;
        step();
        chk("en rise grant 1", 8'(gn[0]), 8'h0d);
        en = 1'b0;
        step();
        chk("en fall release", 8'(gn[0]), 8'h0f);
        en  = 1'b1;
        req = 4'b0000;
        step();

        // timeout with MAX_HOLD=3
        pulse_reset();
        req = 4'b0011;
        for (int c = 1; c <= 5; c++) begin
            step();
            e = (c <= 3) ? 4'b1110 : (c == 4) ? 4'b1111 : 4'b1101;
            chk($sformatf("timeout c=%0d", c), 8'(gn[2]), 8'(e));
        end

        // early drop at cycle 2: single release, then grant 1
        pulse_reset();
        req = 4'b0011;
        step();
        step();
        req = 4'b0010;
        step();
        chk("early drop release", 8'(gn[2]), 8'h0f);
        step();
        chk("early drop next grant", 8'(gn[2]), 8'h0d);
        step();
        chk("early drop hold", 8'(gn[2]), 8'h0d);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
